// File: rtl/stopwatch_ctrl_pkg.sv
// Shared constants for the stopwatch front-panel controller: state encodings,
// BCD digit/time widths and digit lane offsets within the packed time word.
package stopwatch_ctrl_pkg;

  localparam int BCD_W  = 4;
  localparam int TIME_W = 32;

  localparam logic [1:0] SW_IDLE  = 2'b00;
  localparam logic [1:0] SW_RUN   = 2'b01;
  localparam logic [1:0] SW_LAP   = 2'b10;
  localparam logic [1:0] SW_PAUSE = 2'b11;

  // Packing: {decahr,hr,decamin,min,decasec,sec,decisec,centisec}
  localparam int LANE_CENTISEC = 0;
  localparam int LANE_DECISEC  = 4;
  localparam int LANE_SEC      = 8;
  localparam int LANE_DECASEC  = 12;
  localparam int LANE_MIN      = 16;
  localparam int LANE_DECAMIN  = 20;
  localparam int LANE_HR       = 24;
  localparam int LANE_DECAHR   = 28;

  typedef logic [TIME_W-1:0] sw_time_t;

endpackage

// File: rtl/stopwatch_ctrl_button_debounce.sv
// Raw push-button conditioning: 2-FF synchroniser, stability counter and a
// registered one-cycle press pulse on the debounced rising edge.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The press pulse is registered in the same cycle the level flips high,
  // keeping the raw-to-command latency at DEBOUNCE_CYCLES+3.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
        press_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel controller: debounced start/stop and lap/reset buttons
// drive a run/lap/pause FSM and the live-or-lap display mux.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_stop_btn_i,
  input  logic              lap_reset_btn_i,
  input  logic [TIME_W-1:0] live_time_i,
  output logic              run_pause_o,
  output logic              sw_reset_o,
  output logic [TIME_W-1:0] disp_time_o,
  output logic              lap_hold_o,
  output logic [1:0]        state_o
);

  logic     ss_press, lr_press;
  logic [1:0] state_q, state_d;
  logic     run_pause_q, run_pause_d;
  logic     sw_reset_q, sw_reset_d;
  logic     lap_hold_q, lap_hold_d;
  sw_time_t snap_q, snap_d;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss_db (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .btn_i   (start_stop_btn_i),
    .press_o (ss_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lr_db (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .btn_i   (lap_reset_btn_i),
    .press_o (lr_press)
  );

  // Start/stop takes priority; a coincident lap/reset press is dropped.
  always_comb begin
    state_d     = state_q;
    run_pause_d = 1'b0;
    sw_reset_d  = 1'b0;
    lap_hold_d  = lap_hold_q;
    snap_d      = snap_q;
    case (state_q)
      SW_IDLE: begin
        if (ss_press) begin
          state_d     = SW_RUN;
          run_pause_d = 1'b1;
        end
      end
      SW_RUN: begin
        if (ss_press) begin
          state_d     = SW_PAUSE;
          run_pause_d = 1'b1;
        end else if (lr_press) begin
          state_d    = SW_LAP;
          lap_hold_d = 1'b1;
          snap_d     = live_time_i;
        end
      end
      SW_LAP: begin
        if (ss_press) begin
          state_d     = SW_PAUSE;
          run_pause_d = 1'b1;
          lap_hold_d  = 1'b0;
        end else if (lr_press) begin
          state_d    = SW_RUN;
          lap_hold_d = 1'b0;
        end
      end
      SW_PAUSE: begin
        if (ss_press) begin
          state_d     = SW_RUN;
          run_pause_d = 1'b1;
        end else if (lr_press) begin
          state_d    = SW_IDLE;
          sw_reset_d = 1'b1;
        end
      end
      default: state_d = SW_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= SW_IDLE;
      run_pause_q <= 1'b0;
      sw_reset_q  <= 1'b0;
      lap_hold_q  <= 1'b0;
      snap_q      <= '0;
    end else begin
      state_q     <= state_d;
      run_pause_q <= run_pause_d;
      sw_reset_q  <= sw_reset_d;
      lap_hold_q  <= lap_hold_d;
      snap_q      <= snap_d;
    end
  end

  assign run_pause_o = run_pause_q;
  assign sw_reset_o  = sw_reset_q;
  assign lap_hold_o  = lap_hold_q;
  assign state_o     = state_q;
  assign disp_time_o = lap_hold_q ? snap_q : live_time_i;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4 and a 10 ns clock;
// inputs change and outputs are sampled on the falling edge.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ss = 1'b0;
  logic        lr = 1'b0;
  logic [31:0] live = 32'h0;
  logic        run_pause, sw_reset, lap_hold;
  logic [31:0] disp;
  logic [1:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  int rp_cnt, rp_first, sr_cnt, overlap;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .start_stop_btn_i (ss),
    .lap_reset_btn_i  (lr),
    .live_time_i      (live),
    .run_pause_o      (run_pause),
    .sw_reset_o       (sw_reset),
    .disp_time_o      (disp),
    .lap_hold_o       (lap_hold),
    .state_o          (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Raise the selected buttons, hold for hold_cyc samples, then observe the
  // remainder of an ncyc-cycle window while tallying command pulses.
  task automatic press(input bit do_ss, input bit do_lr, input int hold_cyc, input int ncyc);
    rp_cnt = 0; rp_first = -1; sr_cnt = 0; overlap = 0;
    ss = do_ss;
    lr = do_lr;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (run_pause) begin
        rp_cnt++;
        if (rp_first < 0) rp_first = k;
      end
      if (sw_reset) sr_cnt++;
      if (run_pause && sw_reset) overlap++;
      if (k == hold_cyc) begin
        ss = 1'b0;
        lr = 1'b0;
      end
    end
  endtask

  initial begin
    // 1: reset
    live  = 32'h00012345;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_state", 32'(state), 32'h0);
    check("rst_rp", 32'(run_pause), 32'h0);
    check("rst_sr", 32'(sw_reset), 32'h0);
    check("rst_hold", 32'(lap_hold), 32'h0);
    check("rst_disp", disp, 32'h00012345);
    reset = 1'b0;
    @(negedge clk);

    // 3: short SS glitch ignored
    press(1'b1, 1'b0, 3, 16);
    check("glitch_rp", 32'(rp_cnt), 32'd0);
    check("glitch_state", 32'(state), 32'h0);

    // 2: SS press from IDLE, latency 7
    press(1'b1, 1'b0, 10, 20);
    check("start_rp_cnt", 32'(rp_cnt), 32'd1);
    check("start_rp_lat", 32'(rp_first), 32'd7);
    check("start_state", 32'(state), 32'h1);

    // 4: lap freeze and release
    live = 32'h00012345;
    press(1'b0, 1'b1, 10, 20);
    check("lap_state", 32'(state), 32'h2);
    check("lap_hold", 32'(lap_hold), 32'h1);
    check("lap_rp", 32'(rp_cnt), 32'd0);
    live = 32'h00012399;
    @(negedge clk);
    check("lap_frozen", disp, 32'h00012345);
    press(1'b0, 1'b1, 10, 20);
    check("unlap_state", 32'(state), 32'h1);
    check("unlap_hold", 32'(lap_hold), 32'h0);
    check("unlap_disp", disp, 32'h00012399);

    // 5: pause then clear, then LR in IDLE ignored
    press(1'b1, 1'b0, 10, 20);
    check("pause_state", 32'(state), 32'h3);
    check("pause_rp", 32'(rp_cnt), 32'd1);
    press(1'b0, 1'b1, 10, 20);
    check("clear_sr", 32'(sr_cnt), 32'd1);
    check("clear_rp", 32'(rp_cnt), 32'd0);
    check("clear_state", 32'(state), 32'h0);
    press(1'b0, 1'b1, 10, 20);
    check("idle_lr_sr", 32'(sr_cnt), 32'd0);
    check("idle_lr_state", 32'(state), 32'h0);

    // 6: simultaneous press, SS wins
    press(1'b1, 1'b0, 10, 20);
    check("run2_state", 32'(state), 32'h1);
    live = 32'h00005678;
    press(1'b1, 1'b1, 10, 20);
    check("both_state", 32'(state), 32'h3);
    check("both_rp", 32'(rp_cnt), 32'd1);
    check("both_sr", 32'(sr_cnt), 32'd0);
    check("both_hold", 32'(lap_hold), 32'h0);
    check("both_overlap", 32'(overlap), 32'd0);

    // reset while in LAP
    press(1'b1, 1'b0, 10, 20);
    press(1'b0, 1'b1, 10, 20);
    check("lap2_state", 32'(state), 32'h2);
    live = 32'h00009999;
    reset = 1'b1;
    @(negedge clk);
    check("lrst_state", 32'(state), 32'h0);
    check("lrst_hold", 32'(lap_hold), 32'h0);
    check("lrst_rp", 32'(run_pause), 32'h0);
    check("lrst_sr", 32'(sw_reset), 32'h0);
    check("lrst_disp", disp, 32'h00009999);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
